bpsk_tx_sched: RTL
==================

# bpsk_tx_sched

Transmit scheduler for the BPSK slicer. It arbitrates between two frame sources and sequences each granted frame into 32-bit words on the slicer's word handshake. Each frame is sent as preamble, header, payload and checksum, followed by an enforced idle gap. It sits between the link-layer producers (game-state and control queues) and the slicer.

## Interface
Parameters:
- GAP, 64: cycles with s_valid held low after the checksum word's ack, before the next arbitration.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- req_i  in  2  per-source frame request, level.
- len0_i, len1_i  in  8  payload length in words for each source; sampled at grant.
- pop_o  out  2  one-hot, one-cycle read pulse to the granted source's word queue.
- data0_i, data1_i  in  32  source word; valid the cycle after the matching pop_o bit.
- grant_o  out  2  one-hot; held from grant until the GAP state is entered.
- busy_o  out  1  high in every state except IDLE.
- s_valid  out  1  word valid to the slicer.
- s_data  out  32  word to the slicer, serialized LSB-first.
- s_ack  in  1  slicer word-accept pulse; means the word was captured on the previous edge.

## Operation
- States: IDLE, PRE, HDR, PAY, CSUM, GAP. Encoded one-hot.
- IDLE:
  - If any req_i bit is set, the round-robin arbiter picks a source g.
  - Latch g and len_g, set grant_o, go to PRE.
  - Round-robin rule: the pointer favours src0 after reset and flips to the other source after every completed frame.
  - If both sources request, the source favoured by the pointer wins.
- PRE: word = PREAMBLE 32'hD555_5555.
- HDR: word = {8'hC3, 7'b0, g, 8'h00, len}.
- PAY:
  - Sends len words from source g, in pop order.
  - A word counter counts up to len.
  - len=0 skips PAY: HDR goes directly to CSUM.
- CSUM: word = XOR of the header word and all payload words, accumulated in a 32-bit register.
- GAP:
  - grant_o=0, s_valid=0.
  - Counts GAP cycles, then returns to IDLE.
  - The round-robin pointer updates on entry to GAP.
- A word is presented by setting s_valid=1 with s_data stable. It is held until s_ack is sampled high.
- State advances only on s_ack. s_ack while s_valid=0 is ignored.
- req_i changes after grant are ignored; the frame always completes with the latched len.
- Reset (including mid-frame): the state machine returns to IDLE immediately. The frame is truncated and never resumed. All outputs return to their reset values.

## Timing
- Reset values: s_valid=0, s_data=0, pop_o=0, grant_o=0, busy_o=0, pointer favours src0, checksum register=0.
- Grant: req_i sampled high in IDLE at edge T. Then grant_o and busy_o are high from T+1, and the PRE word has s_valid=1 at T+1.
- Word spacing: s_ack sampled high at edge A, then:
  - A+1: s_valid=0. If the next word is payload, pop_o[g]=1.
  - A+2: s_valid=0, pop_o=0; data_g_i is valid.
  - A+3: s_valid=1 with the next word (payload captured from data_g_i).
- The 2-cycle s_valid gap falls well inside the slicer's 32-cycle word time, so the serialized stream stays continuous across words within a frame.
- After the CSUM ack at A: grant_o=0 from A+1, and s_valid stays low for GAP cycles (A+1 … A+GAP). The earliest next grant is at edge A+GAP+1.
- Frame length in words = len+3.
- The checksum register clears at grant. Header and payload XOR into it as each word is loaded into s_data.

## Structure
- Package bpsk_frame_pkg holds: PREAMBLE, SYNC (8'hC3), state encoding constants, default GAP.
- Sub-module bpsk_rr_arb: 2-way round-robin arbiter.
  - Inputs: req, advance.
  - Output: one-hot pick.
  - Owns the pointer register, with asynchronous active-low reset on RST.
- Everything else lives in the top level: state machine, word counter, gap counter, checksum register, output registers.

## Test plan
- src0 req, len=2, data 32'h1111_1111 then 32'h2222_2222; the slicer model acks each word → s_data sequence D555_5555, C300_0002, 1111_1111, 2222_2222, F033_3331; exactly 2 pop_o[0] pulses.
- src1 req, len=0 → words D555_5555, C301_0000, C301_0000; no pop_o pulses.
- Both req_i=2'b11 held continuously, len=1 each → grants alternate src0, src1, src0; consecutive CSUM ack to next grant_o rise = GAP+1 cycles.
- Slicer model delays s_ack by 31 cycles per word → s_valid and s_data stay stable until the ack; next word appears exactly 3 cycles after the ack.
- RST low mid-PAY of a len=4 frame → all outputs 0 within the reset; after release with src1 requesting, src1 is granted and the frame starts from PRE.
- req_i[0] dropped right after grant, len=3 → frame still completes with 3 payload words and a correct checksum.

Source files
------------

// File: rtl/bpsk_frame_pkg.sv
// Shared frame constants and state encoding for the BPSK transmit scheduler.
package bpsk_frame_pkg;

  localparam logic [31:0] PREAMBLE = 32'hD555_5555;
  localparam logic [7:0]  SYNC     = 8'hC3;
  localparam int          GAP_DEF  = 64;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_PRE  = 6'b000010,
    S_HDR  = 6'b000100,
    S_PAY  = 6'b001000,
    S_CSUM = 6'b010000,
    S_GAP  = 6'b100000
  } state_t;

  function automatic logic [31:0] hdr_word(input logic g, input logic [7:0] len);
    return {SYNC, 7'b0, g, 8'h00, len};
  endfunction

endpackage

// File: rtl/bpsk_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the favoured source and flips on advance.
module bpsk_rr_arb (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] pick
);

  logic r_ptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_ptr <= 1'b0;
    else if (advance) r_ptr <= ~r_ptr;
  end

  always_comb begin
    pick = 2'b00;
    if (r_ptr == 1'b0) begin
      if (req[0])      pick = 2'b01;
      else if (req[1]) pick = 2'b10;
    end else begin
      if (req[1])      pick = 2'b10;
      else if (req[0]) pick = 2'b01;
    end
  end

endmodule

// File: rtl/bpsk_tx_sched.sv
// Arbitrates two frame sources and streams preamble/header/payload/checksum words to the slicer.
module bpsk_tx_sched
  import bpsk_frame_pkg::*;
#(
  parameter int GAP = GAP_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  req_i,
  input  logic [7:0]  len0_i,
  input  logic [7:0]  len1_i,
  output logic [1:0]  pop_o,
  input  logic [31:0] data0_i,
  input  logic [31:0] data1_i,
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic        s_valid,
  output logic [31:0] s_data,
  input  logic        s_ack
);

  state_t      r_state, w_state_nxt;
  logic        w_ack, w_grant_ev, w_advance, w_pop_req, w_load;
  logic [1:0]  w_pick;
  logic [31:0] w_word;

  logic        r_g;
  logic [7:0]  r_len, r_cnt;
  logic [1:0]  r_ph;
  logic [15:0] r_gap;
  logic [31:0] r_csum;
  logic        r_s_valid;
  logic [31:0] r_s_data;
  logic [1:0]  r_pop, r_grant;

  assign w_ack      = s_ack & r_s_valid;
  assign w_grant_ev = (r_state == S_IDLE) & (|req_i);
  assign w_advance  = w_ack & (r_state == S_CSUM);
  assign w_load     = (r_ph == 2'd2);

  bpsk_rr_arb u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req_i),
    .advance (w_advance),
    .pick    (w_pick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (|req_i) w_state_nxt = S_PRE;
      S_PRE:  if (w_ack)  w_state_nxt = S_HDR;
      S_HDR:  if (w_ack)  w_state_nxt = (r_len == 8'd0) ? S_CSUM : S_PAY;
      S_PAY:  if (w_ack && (r_cnt == r_len)) w_state_nxt = S_CSUM;
      S_CSUM: if (w_ack)  w_state_nxt = S_GAP;
      S_GAP:  if (r_gap == 16'(GAP - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word for the state just entered; loaded two cycles after the previous ack.
  always_comb begin
    busy_o    = (r_state != S_IDLE);
    w_pop_req = w_ack & (((r_state == S_HDR) & (r_len != 8'd0)) |
                         ((r_state == S_PAY) & (r_cnt != r_len)));
    case (r_state)
      S_HDR:   w_word = hdr_word(r_g, r_len);
      S_PAY:   w_word = r_g ? data1_i : data0_i;
      S_CSUM:  w_word = r_csum;
      default: w_word = PREAMBLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_g       <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_ph      <= '0;
      r_gap     <= '0;
      r_csum    <= '0;
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_pop     <= '0;
      r_grant   <= '0;
    end else if (w_grant_ev) begin
      r_g       <= w_pick[1];
      r_len     <= w_pick[1] ? len1_i : len0_i;
      r_grant   <= w_pick;
      r_cnt     <= '0;
      r_csum    <= '0;
      r_ph      <= '0;
      r_s_valid <= 1'b1;
      r_s_data  <= PREAMBLE;
    end else if (w_ack) begin
      r_s_valid <= 1'b0;
      r_pop     <= w_pop_req ? (r_g ? 2'b10 : 2'b01) : 2'b00;
      if (r_state == S_CSUM) begin
        r_grant <= '0;
        r_gap   <= '0;
        r_ph    <= '0;
      end else begin
        r_ph    <= 2'd1;
      end
    end else if (r_ph == 2'd1) begin
      r_pop <= '0;
      r_ph  <= 2'd2;
    end else if (w_load) begin
      r_ph      <= '0;
      r_s_valid <= 1'b1;
      r_s_data  <= w_word;
      if ((r_state == S_HDR) || (r_state == S_PAY)) r_csum <= r_csum ^ w_word;
      if (r_state == S_PAY) r_cnt <= r_cnt + 8'd1;
    end else if (r_state == S_GAP) begin
      r_gap <= r_gap + 16'd1;
    end
  end

  assign pop_o   = r_pop;
  assign grant_o = r_grant;
  assign s_valid = r_s_valid;
  assign s_data  = r_s_data;

endmodule
